// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: per-axis 50 Hz servo PWM generator with a bounded
// position register that steps once per frame from a 4-bit angle command.
//
// Ports:
//   i_Clk        system clock
//   i_Rst        synchronous active-high reset
//   i_Cmd        command code (1 step down, 2 step up, 3 recenter, else hold)
//   o_Pwm        registered PWM output, high for o_Position cycles per frame
//   o_Position   current pulse width in clocks
//   o_Frame_Tick one-cycle pulse on the first cycle of each frame
//   o_At_Min     position at MIN_PULSE (only with SERVO_LIMIT_FLAG_EN)
//   o_At_Max     position at MAX_PULSE (only with SERVO_LIMIT_FLAG_EN)
//
// Build option: define SERVO_LIMIT_FLAG_EN to build the limit flags;
// otherwise o_At_Min/o_At_Max are tied low.

module servo_pwm_driver #(
    parameter int FRAME_CYCLES = 500000,
    parameter int MIN_PULSE    = 25000,
    parameter int MAX_PULSE    = 50000,
    parameter int CENTER_PULSE = 37500,
    parameter int STEP         = 250,
    parameter int POS_W        = 20
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [3:0]       i_Cmd,
    output logic             o_Pwm,
    output logic [POS_W-1:0] o_Position,
    output logic             o_Frame_Tick,
    output logic             o_At_Min,
    output logic             o_At_Max
);

    localparam logic [POS_W-1:0] LAST_CNT = POS_W'(FRAME_CYCLES - 1);
    localparam logic [POS_W-1:0] MIN_P    = POS_W'(MIN_PULSE);
    localparam logic [POS_W-1:0] MAX_P    = POS_W'(MAX_PULSE);
    localparam logic [POS_W-1:0] CTR_P    = POS_W'(CENTER_PULSE);
    localparam logic [POS_W-1:0] STEP_P   = POS_W'(STEP);

    // Extended-width bounds so neither direction can wrap.
    localparam logic [POS_W:0] MAX_W   = {1'b0, MAX_P};
    localparam logic [POS_W:0] FLOOR_W = (POS_W+1)'(MIN_PULSE + STEP);

    localparam logic [3:0] CMD_DEC = 4'd1;
    localparam logic [3:0] CMD_INC = 4'd2;
    localparam logic [3:0] CMD_CTR = 4'd3;

    if (!(MIN_PULSE <= CENTER_PULSE &&
          CENTER_PULSE <= MAX_PULSE &&
          MAX_PULSE < FRAME_CYCLES &&
          STEP > 0 &&
          (FRAME_CYCLES - 1) < (1 << POS_W)))
    begin : g_param_check
        $error("servo_pwm_driver: illegal parameter set");
    end

    logic [POS_W-1:0] frame_cnt;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_next;
    logic [POS_W:0]   sum_up;
    logic             at_end;
    logic             is_dec;
    logic             is_inc;
    logic             is_ctr;

    always_comb begin
        at_end = (frame_cnt == LAST_CNT);
        is_dec = (i_Cmd == CMD_DEC);
        is_inc = (i_Cmd == CMD_INC);
        is_ctr = (i_Cmd == CMD_CTR);
        sum_up = {1'b0, pos} + {1'b0, STEP_P};
        pos_next = pos;
        unique case (1'b1)
            is_dec: begin
                // Compare first so pos-STEP is only formed when it stays >= MIN.
                if ({1'b0, pos} < FLOOR_W) begin
                    pos_next = MIN_P;
                end else begin
                    pos_next = pos - STEP_P;
                end
            end
            is_inc: begin
                if (sum_up > MAX_W) begin
                    pos_next = MAX_P;
                end else begin
                    pos_next = sum_up[POS_W-1:0];
                end
            end
            is_ctr: pos_next = CTR_P;
            default: pos_next = pos;
        endcase
    end

    // The position only moves on the last count of a frame, so the pulse
    // of the new frame is always built from a stable width.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            frame_cnt    <= '0;
            pos          <= CTR_P;
            o_Pwm        <= 1'b0;
            o_Frame_Tick <= 1'b0;
        end else begin
            frame_cnt    <= at_end ? '0 : frame_cnt + 1'b1;
            o_Pwm        <= (frame_cnt < pos);
            o_Frame_Tick <= at_end;
            if (at_end) begin
                pos <= pos_next;
            end
        end
    end

    assign o_Position = pos;

`ifdef SERVO_LIMIT_FLAG_EN
    logic at_min;
    logic at_max;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            at_min <= 1'b0;
            at_max <= 1'b0;
        end else if (at_end) begin
            at_min <= (pos_next == MIN_P);
            at_max <= (pos_next == MAX_P);
        end
    end

    assign o_At_Min = at_min;
    assign o_At_Max = at_max;
`else
    assign o_At_Min = 1'b0;
    assign o_At_Max = 1'b0;
`endif

endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver: scoreboard bench for servo_pwm_driver using a
// shortened frame (100 clocks, limits 10..30, center 20, step 5).

module tb_servo_pwm_driver;

    localparam int FC  = 100;
    localparam int MN  = 10;
    localparam int MX  = 30;
    localparam int CT  = 20;
    localparam int ST  = 5;
    localparam int PW  = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    cmd = 4'd0;
    logic          pwm;
    logic [PW-1:0] position;
    logic          tick;
    logic          at_min;
    logic          at_max;

    int n_chk  = 0;
    int n_fail = 0;

    int mcnt = 0;
    int mpos = CT;
    int exp_q[$];

    servo_pwm_driver #(
        .FRAME_CYCLES (FC),
        .MIN_PULSE    (MN),
        .MAX_PULSE    (MX),
        .CENTER_PULSE (CT),
        .STEP         (ST),
        .POS_W        (PW)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Cmd        (cmd),
        .o_Pwm        (pwm),
        .o_Position   (position),
        .o_Frame_Tick (tick),
        .o_At_Min     (at_min),
        .o_At_Max     (at_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int step(input int p, input int c);
        case (c)
            1: return (p - ST < MN) ? MN : p - ST;
            2: return (p + ST > MX) ? MX : p + ST;
            3: return CT;
            default: return p;
        endcase
    endfunction

    function automatic int flag_min(input int p);
`ifdef SERVO_LIMIT_FLAG_EN
        return (p == MN) ? 1 : 0;
`else
        return (p < 0) ? 1 : 0;
`endif
    endfunction

    function automatic int flag_max(input int p);
`ifdef SERVO_LIMIT_FLAG_EN
        return (p == MX) ? 1 : 0;
`else
        return (p < 0) ? 1 : 0;
`endif
    endfunction

    // Reference frame counter, restarted by the same reset as the DUT.
    always @(posedge clk) begin
        if (rst) begin
            mcnt <= 0;
        end else begin
            mcnt <= (mcnt == FC - 1) ? 0 : mcnt + 1;
        end
    end

    // Monitor: checks reset state, tick spacing, pulse widths, and pops
    // one expected position per frame tick.
    int  cyc       = 0;
    int  last_tick = 0;
    bit  have_tick = 0;
    bit  after_rst = 0;
    bit  pend_w    = 0;
    int  exp_w     = 0;
    int  hi_cnt    = 0;

    always @(negedge clk) begin
        int e;
        cyc++;
        if (rst) begin
            after_rst = 1;
            pend_w    = 0;
            have_tick = 0;
        end else if (after_rst) begin
            check("rst_pwm",  pwm, 0);
            check("rst_pos",  position, CT);
            check("rst_tick", tick, 0);
            check("rst_min",  at_min, 0);
            check("rst_max",  at_max, 0);
            after_rst = 0;
            pend_w    = 1;
            exp_w     = CT;
            hi_cnt    = 0;
            last_tick = cyc;
            have_tick = 1;
        end else begin
            if (tick) begin
                if (have_tick) check("tick_gap", cyc - last_tick, FC);
                if (pend_w) check("pulse_w", hi_cnt, exp_w);
                if (exp_q.size() == 0) begin
                    check("sb_empty", exp_q.size(), 1);
                    pend_w = 0;
                end else begin
                    e = exp_q.pop_front();
                    check("pos", position, e);
                    check("at_min", at_min, flag_min(e));
                    check("at_max", at_max, flag_max(e));
                    exp_w  = e;
                    pend_w = 1;
                end
                hi_cnt    = 0;
                last_tick = cyc;
                have_tick = 1;
            end
            hi_cnt += int'(pwm);
        end
    end

    task automatic wait_cnt(input int n);
        for (int i = 0; i < 3 * FC; i++) begin
            @(posedge clk);
            #1;
            if (mcnt == n) return;
        end
        check("timeout_cnt", mcnt, n);
    endtask

    // Drive cmd for the next update point and record the expected result.
    task automatic boundary(input int c);
        wait_cnt(FC - 1);
        cmd  = 4'(c);
        mpos = step(mpos, c);
        exp_q.push_back(mpos);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        mpos = CT;

        boundary(0);
        boundary(0);

        boundary(2);
        boundary(2);
        boundary(2);

        boundary(3);
        boundary(1);
        boundary(1);
        boundary(1);

        boundary(5);
        boundary(3);

        // Step-up request present only away from the update point.
        wait_cnt(40);
        cmd = 4'd2;
        boundary(0);
        boundary(0);

        // Mid-frame reset while at the upper limit.
        boundary(2);
        boundary(2);
        wait_cnt(15);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        mpos = CT;

        boundary(0);
        boundary(1);
        boundary(0);
        repeat (3) @(posedge clk);
        #1;

        check("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
